// File: rtl/jk_pkg.sv
// Shared JK flip-flop encodings and excitation helper.
// The {J,K} pair is packed with J in bit 1 and K in bit 0.
package jk_pkg;

    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

    // Minimal excitation: set on a 0->1 move, reset on 1->0, hold otherwise.
    // Toggle is never produced.
    function automatic logic [1:0] jk_excite(input logic q_bit, input logic nxt_bit);
        logic [1:0] jk;
        jk = JK_HOLD;
        if (!q_bit && nxt_bit) begin
            jk = JK_SET;
        end else if (q_bit && !nxt_bit) begin
            jk = JK_RESET;
        end
        return jk;
    endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop built around a D flop, synchronous active-low reset to 0.
module jk_cell
    import jk_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic j_i,
    input  logic k_i,
    output logic q_o,
    output logic qn_o
);

    logic q_q;
    logic q_d;

    // JK characteristic equation feeding the D input.
    always_comb begin
        q_d = q_q;
        case ({j_i, k_i})
            JK_HOLD:   q_d = q_q;
            JK_RESET:  q_d = 1'b0;
            JK_SET:    q_d = 1'b1;
            JK_TOGGLE: q_d = ~q_q;
            default:   q_d = q_q;
        endcase
    end

    // State flop with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o  = q_q;
    assign qn_o = ~q_q;

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-MOD up/down counter whose state bits are JK cells.
// Optional parallel load with MOD-1 clamp is built when JK_CNT_LOAD_EN is defined.
module jk_mod_counter
    import jk_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned MOD   = 10
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             up_dn_i,
`ifdef JK_CNT_LOAD_EN
    input  logic             load_i,
    input  logic [WIDTH-1:0] d_i,
`endif
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] qn_o,
    output logic             tc_o,
    output logic             wrap_o
);

    localparam logic [WIDTH-1:0] LastVal = WIDTH'(MOD - 1);

    logic [WIDTH-1:0] q_w;
    logic [WIDTH-1:0] qn_w;
    logic [WIDTH-1:0] nxt_d;
    logic [WIDTH-1:0] load_val;
    logic             load_w;
    logic             wrap_q;

    // Load strobe and clamped load value.
    always_comb begin
        load_w   = 1'b0;
        load_val = '0;
`ifdef JK_CNT_LOAD_EN
        load_w   = load_i;
        load_val = ({1'b0, d_i} > {1'b0, LastVal}) ? LastVal : d_i;
`endif
    end

    // Desired next count: load beats count beats hold.
    always_comb begin
        nxt_d = q_w;
        if (load_w) begin
            nxt_d = load_val;
        end else if (en_i) begin
            if (up_dn_i) begin
                nxt_d = (q_w == LastVal) ? '0 : q_w + WIDTH'(1);
            end else begin
                nxt_d = (q_w == '0) ? LastVal : q_w - WIDTH'(1);
            end
        end
    end

    // Per-bit excitation and JK state cells.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [1:0] jk;
        assign jk = jk_excite(q_w[i], nxt_d[i]);

        jk_cell u_cell (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .j_i    (jk[1]),
            .k_i    (jk[0]),
            .q_o    (q_w[i]),
            .qn_o   (qn_w[i])
        );
    end

    assign tc_o = en_i & ~load_w &
                  ((up_dn_i & (q_w == LastVal)) | (~up_dn_i & (q_w == '0)));

    // Wrap pulse follows a counting edge taken while tc was high.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= tc_o;
        end
    end

    assign q_o    = q_w;
    assign qn_o   = qn_w;
    assign wrap_o = wrap_q;

endmodule
